kmeans_assign_ctrl: RTL and testbench

//  Sequences one K-means assignment pass over N_POINTS stored points.
//  Per point: requests the point's 16 distances, enables the first k_active cores on the
//  16-way distance comparator, and captures its one-hot closestCore result.

---
 rtl/kmeans_assign_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_kmeans_assign_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_assign_ctrl.sv
// K-means assignment-pass sequencer: walks every stored point, captures the
// comparator's one-hot winner, writes its core index and keeps per-core
// member counts plus a changed-assignment count for the convergence check.
module kmeans_assign_ctrl #(
    parameter int unsigned N_POINTS = 256,
    parameter int unsigned PW       = 8,
    parameter int unsigned CW       = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          first_pass,
    input  logic [4:0]    k_active,
    input  logic [CW-1:0] thresh,
    output logic          pt_req,
    output logic [PW-1:0] pt_addr,
    input  logic          pt_ack,
    input  logic [3:0]    prev_idx,
    output logic [15:0]   en_cores,
    input  logic [15:0]   closest_core,
    output logic          assign_we,
    output logic [PW-1:0] assign_addr,
    output logic [3:0]    assign_idx,
    input  logic [3:0]    cnt_sel,
    output logic [CW-1:0] cnt_data,
    output logic [CW-1:0] changes,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic          err
);

    localparam int unsigned NCORES = 16;
    localparam logic [PW-1:0] LAST_ADDR = PW'(N_POINTS - 1);

    typedef enum logic [1:0] {IDLE, REQ, UPD, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pt_addr_n;
    logic [4:0]    k_q, k_n;
    logic          fp_q, fp_n;
    logic [3:0]    idx_q, idx_n;
    logic [3:0]    prev_q, prev_n;
    logic [CW-1:0] cnt_q [NCORES];
    logic [CW-1:0] cnt_n [NCORES];
    logic [CW-1:0] changes_n;
    logic          err_n, converged_n;
    logic [15:0]   en_cores_n;
    logic          pt_req_n, busy_n, done_n, assign_we_n;
    logic [PW-1:0] assign_addr_n;
    logic [3:0]    assign_idx_n;
    logic          k_ok;
    logic [3:0]    hot_idx;
    logic          hot_bad;

    // Lowest set bit of the comparator result; zero input maps to core 0.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Decode of the comparator result and start-time k validity.
    always_comb begin
        hot_idx = lowest_idx(closest_core);
        hot_bad = (closest_core == 16'd0) || ((closest_core & (closest_core - 16'd1)) != 16'd0)
                  || ({1'b0, hot_idx} >= k_q);
        k_ok    = (k_active != 5'd0) && (k_active <= 5'd16);
    end

    // Next-state and next-register values.
    always_comb begin
        state_n       = state;
        pt_addr_n     = pt_addr;
        k_n           = k_q;
        fp_n          = fp_q;
        idx_n         = idx_q;
        prev_n        = prev_q;
        cnt_n         = cnt_q;
        changes_n     = changes;
        err_n         = err;
        converged_n   = converged;
        en_cores_n    = en_cores;
        assign_addr_n = assign_addr;
        assign_idx_n  = assign_idx;

        unique case (state)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < int'(NCORES); i++) cnt_n[i] = '0;
                    changes_n   = '0;
                    err_n       = 1'b0;
                    converged_n = 1'b0;
                    pt_addr_n   = '0;
                    k_n         = k_active;
                    fp_n        = first_pass;
                    if (k_ok) begin
                        en_cores_n = 16'((17'd1 << k_active) - 17'd1);
                        state_n    = REQ;
                    end else begin
                        en_cores_n = 16'd0;
                        err_n      = 1'b1;
                        state_n    = DONE;
                    end
                end
            end
            REQ: begin
                if (pt_ack) begin
                    idx_n   = hot_idx;
                    prev_n  = prev_idx;
                    if (hot_bad) err_n = 1'b1;
                    state_n = UPD;
                end
            end
            UPD: begin
                cnt_n[idx_q] = cnt_q[idx_q] + CW'(1);
                if (fp_q || (idx_q != prev_q)) changes_n = changes + CW'(1);
                if (pt_addr == LAST_ADDR) begin
                    state_n = DONE;
                end else begin
                    pt_addr_n = pt_addr + PW'(1);
                    state_n   = REQ;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n == UPD) begin
            assign_addr_n = pt_addr;
            assign_idx_n  = idx_n;
        end
        if (state_n == DONE) converged_n = (changes_n <= thresh);

        pt_req_n    = (state_n == REQ);
        busy_n      = (state_n == REQ) || (state_n == UPD);
        done_n      = (state_n == DONE);
        assign_we_n = (state_n == UPD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pt_addr     <= '0;
            k_q         <= '0;
            fp_q        <= 1'b0;
            idx_q       <= '0;
            prev_q      <= '0;
            for (int i = 0; i < int'(NCORES); i++) cnt_q[i] <= '0;
            changes     <= '0;
            err         <= 1'b0;
            converged   <= 1'b0;
            en_cores    <= '0;
            pt_req      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            assign_we   <= 1'b0;
            assign_addr <= '0;
            assign_idx  <= '0;
        end else begin
            state       <= state_n;
            pt_addr     <= pt_addr_n;
            k_q         <= k_n;
            fp_q        <= fp_n;
            idx_q       <= idx_n;
            prev_q      <= prev_n;
            cnt_q       <= cnt_n;
            changes     <= changes_n;
            err         <= err_n;
            converged   <= converged_n;
            en_cores    <= en_cores_n;
            pt_req      <= pt_req_n;
            busy        <= busy_n;
            done        <= done_n;
            assign_we   <= assign_we_n;
            assign_addr <= assign_addr_n;
            assign_idx  <= assign_idx_n;
        end
    end

    assign cnt_data = cnt_q[cnt_sel];

endmodule

// File: tb/tb_kmeans_assign_ctrl.sv
// Self-checking bench for kmeans_assign_ctrl with a 4-point configuration.
module tb_kmeans_assign_ctrl;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, first_pass, pt_ack;
    logic [4:0]    k_active;
    logic [CW-1:0] thresh;
    logic          pt_req;
    logic [PW-1:0] pt_addr;
    logic [3:0]    prev_idx;
    logic [15:0]   en_cores, closest_core;
    logic          assign_we;
    logic [PW-1:0] assign_addr;
    logic [3:0]    assign_idx, cnt_sel;
    logic [CW-1:0] cnt_data, changes;
    logic          busy, done, converged, err;

    int errors = 0;
    int checks = 0;

    logic [15:0] cc [N];
    logic [3:0]  pv [N];
    int          dly [N];
    int          mid_pt;

    always #5 clk = ~clk;

    kmeans_assign_ctrl #(.N_POINTS(N), .PW(PW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_pass(first_pass),
        .k_active(k_active), .thresh(thresh), .pt_req(pt_req), .pt_addr(pt_addr),
        .pt_ack(pt_ack), .prev_idx(prev_idx), .en_cores(en_cores),
        .closest_core(closest_core), .assign_we(assign_we), .assign_addr(assign_addr),
        .assign_idx(assign_idx), .cnt_sel(cnt_sel), .cnt_data(cnt_data),
        .changes(changes), .busy(busy), .done(done), .converged(converged), .err(err)
    );

    // Reference decode: lowest set bit, zero maps to core 0.
    function automatic int low_idx(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic set_pts(input logic [15:0] c0, c1, c2, c3, input logic [3:0] p0, p1, p2, p3);
        cc[0] = c0; cc[1] = c1; cc[2] = c2; cc[3] = c3;
        pv[0] = p0; pv[1] = p1; pv[2] = p2; pv[3] = p3;
        for (int i = 0; i < N; i++) dly[i] = 0;
        mid_pt = -1;
    endtask

    // Runs one pass against the reference model; starts and ends on a falling edge.
    task automatic run_pass(input int k, input bit fp, input int th);
        int  exp_cnt [16];
        int  exp_idx [N];
        int  exp_chg, sum_d, nwr, cyc, busy_cyc, done_cyc, wait_cnt, exp_done;
        bit  exp_err, kbad, saw_req;
        logic [15:0] exp_en;
        kbad = (k == 0) || (k > 16);
        exp_err = kbad; exp_chg = 0; sum_d = 0;
        for (int i = 0; i < 16; i++) exp_cnt[i] = 0;
        exp_en = kbad ? 16'd0 : 16'((1 << k) - 1);
        if (!kbad) begin
            for (int p = 0; p < N; p++) begin
                exp_idx[p] = low_idx(cc[p]);
                if (cc[p] == 16'd0 || $countones(cc[p]) != 1 || exp_idx[p] >= k) exp_err = 1'b1;
                exp_cnt[exp_idx[p]]++;
                if (fp || exp_idx[p] != int'(pv[p])) exp_chg++;
                sum_d += dly[p];
            end
        end
        exp_done = kbad ? 0 : 2 * N + sum_d;

        @(negedge clk);
        start = 1'b1; k_active = 5'(k); first_pass = fp; thresh = CW'(th);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; busy_cyc = -1; done_cyc = -1; nwr = 0; wait_cnt = 0; saw_req = 1'b0;
        while (cyc < 200) begin
            if (busy && busy_cyc < 0) busy_cyc = cyc;
            if (assign_we) begin
                checks++;
                if (nwr >= N || assign_addr !== PW'(nwr) || assign_idx !== 4'(exp_idx[nwr])) begin
                    errors++;
                    $display("FAIL write: addr=%0d idx=%0d, required addr=%0d idx=%0d (write #%0d)",
                             assign_addr, assign_idx, nwr, (nwr < N) ? exp_idx[nwr] : -1, nwr);
                end
                nwr++;
            end
            if (pt_req) begin
                saw_req = 1'b1;
                checks++;
                if (pt_addr !== PW'(nwr)) begin
                    errors++;
                    $display("FAIL pt_addr: got %0d, required %0d", pt_addr, nwr);
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = (mid_pt >= 0 && pt_req && nwr == mid_pt);
            if (pt_req && nwr < N) begin
                if (wait_cnt < dly[nwr]) begin
                    pt_ack = 1'b0; closest_core = 16'($urandom); prev_idx = 4'($urandom);
                    wait_cnt++;
                end else begin
                    pt_ack = 1'b1; closest_core = cc[nwr]; prev_idx = pv[nwr];
                    wait_cnt = 0;
                end
            end else begin
                pt_ack = 1'($urandom); closest_core = 16'($urandom); prev_idx = 4'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        pt_ack = 1'b0; start = 1'b0;

        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL done_timing: done at cycle %0d, required %0d (k=%0d)", done_cyc, exp_done, k);
        end
        if (done_cyc < 0) return;
        checks++;
        if (busy_cyc != (kbad ? -1 : 0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy: rose at %0d busy_at_done=%b, required rise %0d and 0", busy_cyc, busy, kbad ? -1 : 0);
        end
        checks++;
        if (nwr != (kbad ? 0 : N) || saw_req != !kbad) begin
            errors++;
            $display("FAIL write_count: writes=%0d req_seen=%b, required %0d and %b", nwr, saw_req, kbad ? 0 : N, !kbad);
        end
        checks++;
        if (changes !== CW'(exp_chg) || err !== exp_err || converged !== (exp_chg <= th) || en_cores !== exp_en) begin
            errors++;
            $display("FAIL pass_result: changes=%0d err=%b conv=%b en=%h, required %0d %b %b %h",
                     changes, err, converged, en_cores, exp_chg, exp_err, exp_chg <= th, exp_en);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || pt_req !== 1'b0 || converged !== (exp_chg <= th) || err !== exp_err) begin
            errors++;
            $display("FAIL idle_hold: done=%b req=%b conv=%b err=%b, required 0 0 %b %b",
                     done, pt_req, converged, err, exp_chg <= th, exp_err);
        end
        for (int i = 0; i < 16; i++) begin
            cnt_sel = 4'(i);
            #1;
            checks++;
            if (cnt_data !== CW'(exp_cnt[i])) begin
                errors++;
                $display("FAIL cnt[%0d]: got %0d, required %0d", i, cnt_data, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if (pt_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || assign_we !== 1'b0 ||
            changes !== '0 || en_cores !== 16'd0 || err !== 1'b0 || converged !== 1'b0 || cnt_data !== '0) begin
            errors++;
            $display("FAIL reset_values: req=%b busy=%b done=%b we=%b chg=%0d en=%h err=%b conv=%b, required all 0",
                     pt_req, busy, done, assign_we, changes, en_cores, err, converged);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; k_active = 5'd4; first_pass = 1'b1; thresh = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pt_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup: req=%b busy=%b, required 1 1", pt_req, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pt_req !== 1'b0 || assign_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || en_cores !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: req=%b we=%b busy=%b done=%b en=%h, required 0",
                     pt_req, assign_we, busy, done, en_cores);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (pt_req !== 1'b0 || busy !== 1'b0 || assign_we !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: req=%b busy=%b we=%b done=%b, required 0", pt_req, busy, assign_we, done);
            end
        end
    endtask

    task automatic test_basic;
        set_pts(16'h1, 16'h2, 16'h2, 16'h8, 4'd0, 4'd0, 4'd0, 4'd0);
        run_pass(4, 1'b1, 7);
    endtask

    task automatic test_convergence;
        set_pts(16'h1, 16'h2, 16'h2, 16'h8, 4'd0, 4'd1, 4'd1, 4'd2);
        run_pass(4, 1'b0, 1);
        run_pass(4, 1'b0, 0);
    endtask

    task automatic test_stall;
        set_pts(16'h1, 16'h2, 16'h2, 16'h8, 4'd0, 4'd0, 4'd0, 4'd0);
        dly[2] = 3;
        run_pass(4, 1'b1, 7);
    endtask

    task automatic test_bad_inputs;
        set_pts(16'h1, 16'h0, 16'h2, 16'h8, 4'd0, 4'd0, 4'd0, 4'd0);
        run_pass(4, 1'b1, 7);
        set_pts(16'h1, 16'h6, 16'h1, 16'h2, 4'd0, 4'd1, 4'd0, 4'd1);
        run_pass(4, 1'b0, 3);
        set_pts(16'h1, 16'h2, 16'h8, 16'h1, 4'd0, 4'd1, 4'd3, 4'd0);
        run_pass(2, 1'b0, 0);
        run_pass(0, 1'b1, 2);
        run_pass(17, 1'b0, 0);
    endtask

    task automatic test_start_during_busy;
        set_pts(16'h1, 16'h2, 16'h2, 16'h8, 4'd0, 4'd0, 4'd0, 4'd0);
        mid_pt = 1;
        dly[1] = 2;
        run_pass(4, 1'b1, 7);
    endtask

    task automatic test_random;
        int k;
        for (int n = 0; n < 25; n++) begin
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) * 17 + int'($urandom_range(0, 1)) * 5 : int'($urandom_range(1, 16));
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 5) == 0 || k == 0 || k > 16) cc[p] = 16'($urandom);
                else cc[p] = 16'(1 << $urandom_range(0, k - 1));
                pv[p]  = 4'($urandom);
                dly[p] = int'($urandom_range(0, 3));
            end
            mid_pt = int'($urandom_range(0, 5)) - 1;
            run_pass(k, 1'($urandom), int'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        start = 1'b0; first_pass = 1'b0; k_active = '0; thresh = '0;
        pt_ack = 1'b0; prev_idx = '0; closest_core = '0; cnt_sel = '0;
        mid_pt = -1;
        test_reset;
        test_basic;
        test_convergence;
        test_stall;
        test_bad_inputs;
        test_start_during_busy;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
